// File: rtl/mul_pkg.sv
// Constants, product type and serializer state encoding shared by the
// multiplier, its result serializer and their benches.
package mul_pkg;

  localparam int unsigned PROD_W = 256;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned NWORDS = PROD_W / OUT_W;
  // The serializer assumes NWORDS >= 2 so that the index has at least one bit.
  localparam int unsigned IDX_W  = $clog2(NWORDS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [OUT_W-1:0]  word_t;

  typedef enum logic {StIdle, StSend} state_e;

endpackage

// File: rtl/mul_result_serializer_if.sv
// Narrow valid/ready result stream carrying the product one word at a time.
interface mul_result_serializer_if;
  import mul_pkg::*;

  word_t dout;
  logic  dout_valid;
  logic  dout_ready;
  logic  dout_last;

  modport master (output dout, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: a one-cycle-delayed copy of the level, and
// rise = level & ~level_d. A level already high after reset counts as a rise.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/mul_result_serializer.sv
// Captures the multiplier product on the rising edge of done and streams it
// LSW first as OUT_W-bit words; rises arriving while busy are dropped and flagged.
module mul_result_serializer
  import mul_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    done,
  input  prod_t                   yout,
  mul_result_serializer_if.master stream,
  output logic                    busy,
  output logic                    overrun
);

  state_e           state;
  prod_t            shreg;
  logic [IDX_W-1:0] idx;
  logic             valid_r;
  logic             last_r;
  logic             overrun_r;
  logic             rise;
  logic             hs;
  logic             hs_last;

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .level (done),
    .rise  (rise)
  );

  assign hs      = valid_r & stream.dout_ready;
  assign hs_last = hs & last_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      shreg     <= '0;
      idx       <= '0;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rise) begin
            shreg   <= yout;
            idx     <= '0;
            valid_r <= 1'b1;
            last_r  <= 1'b0;
            state   <= StSend;
          end
        end
        StSend: begin
          if (hs_last) begin
            // A rise coinciding with the final handshake chains straight on.
            if (rise) begin
              shreg  <= yout;
              idx    <= '0;
              last_r <= 1'b0;
            end else begin
              shreg   <= '0;
              idx     <= '0;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              state   <= StIdle;
            end
          end else begin
            if (hs) begin
              shreg  <= shreg >> OUT_W;
              idx    <= idx + 1'b1;
              last_r <= (idx == LAST_IDX - 1'b1);
            end
            if (rise) begin
              overrun_r <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // The current word always sits in the low slice of the shift register,
  // which is cleared whenever nothing is in flight.
  assign stream.dout       = shreg[OUT_W-1:0];
  assign stream.dout_valid = valid_r;
  assign stream.dout_last  = last_r;
  assign busy              = valid_r;
  assign overrun           = overrun_r;

endmodule

// File: tb/tb_mul_result_serializer.sv
// Directed bench for mul_result_serializer: basic stream, backpressure, level
// done, overrun, back-to-back products and asynchronous reset mid-stream.
module tb_mul_result_serializer;
  import mul_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  done;
  prod_t yout;
  logic  busy;
  logic  overrun;

  int checks;
  int errors;

  mul_result_serializer_if stream ();

  mul_result_serializer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .done    (done),
    .yout    (yout),
    .stream  (stream),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; results of that edge are then visible.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic prod_t mk_a();
    prod_t p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = 32'h1111_1111 * (i + 1);
    return p;
  endfunction

  function automatic prod_t mk_b();
    prod_t p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = 32'hA0 + i;
    return p;
  endfunction

  function automatic logic [31:0] word_of(input prod_t p, input int i);
    return p[i*32 +: 32];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(stream.dout_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),              64'd0);
    chk({tag, "_dout"},  64'(stream.dout),       64'd0);
    chk({tag, "_last"},  64'(stream.dout_last),  64'd0);
  endtask

  // Pulse done for one edge with the given product.
  task automatic launch(input prod_t p);
    yout = p;
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // Consume words first..7 of p with ready high, checking each one.
  task automatic drain(input string tag, input prod_t p, input int first);
    for (int i = first; i < 8; i++) begin
      chk({tag, "_valid"}, 64'(stream.dout_valid), 64'd1);
      chk({tag, "_dout"},  64'(stream.dout),       64'(word_of(p, i)));
      chk({tag, "_last"},  64'(stream.dout_last),  64'(i == 7));
      chk({tag, "_ovr"},   64'(overrun),           64'd0);
      step();
    end
  endtask

  initial begin
    prod_t pa;
    prod_t pb;
    prod_t pf;
    int    k;
    int    cyc;
    int    nvalid;
    logic  saw_ovr;

    checks = 0;
    errors = 0;
    pa = mk_a();
    pb = mk_b();
    pf = '1;

    // Reset for 1us
    rst_n = 1'b0;
    done  = 1'b0;
    yout  = '0;
    stream.dout_ready = 1'b1;
    #1000;
    chk_idle("rst");
    chk("rst_ovr", 64'(overrun), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1. Basic stream: valid one cycle after the done edge, one word per cycle
    launch(pa);
    chk("basic_first", 64'(stream.dout), 64'h1111_1111);
    drain("basic", pa, 0);
    chk_idle("basic_end");

    // 2. Backpressure with ready pattern 1,0,0,1
    launch(pa);
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 64) begin
      stream.dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      chk("bp_valid", 64'(stream.dout_valid), 64'd1);
      chk("bp_dout",  64'(stream.dout),       64'(word_of(pa, k)));
      chk("bp_last",  64'(stream.dout_last),  64'(k == 7));
      step();
      if (stream.dout_ready) k++;
      cyc++;
    end
    chk("bp_all_words", 64'(k), 64'd8);
    stream.dout_ready = 1'b1;
    chk_idle("bp_end");

    // 3. Level done for 1000 cycles: exactly one product, no overrun
    yout    = pa;
    done    = 1'b1;
    nvalid  = 0;
    saw_ovr = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (stream.dout_valid) nvalid++;
      if (overrun) saw_ovr = 1'b1;
    end
    done = 1'b0;
    step();
    chk("lvl_words", 64'(nvalid), 64'd8);
    chk("lvl_ovr",   64'(saw_ovr), 64'd0);
    chk_idle("lvl_end");

    // 4. Overrun: second rise (all-F) while word 3 is pending under backpressure
    launch(pa);
    for (int i = 0; i < 3; i++) step();
    stream.dout_ready = 1'b0;
    chk("ovr_pend", 64'(stream.dout), 64'(word_of(pa, 3)));
    yout = pf;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("ovr_pulse", 64'(overrun),           64'd1);
    chk("ovr_hold",  64'(stream.dout),       64'(word_of(pa, 3)));
    chk("ovr_vld",   64'(stream.dout_valid), 64'd1);
    step();
    chk("ovr_one_cycle", 64'(overrun),     64'd0);
    chk("ovr_hold2",     64'(stream.dout), 64'(word_of(pa, 3)));
    stream.dout_ready = 1'b1;
    drain("ovr_rest", pa, 3);
    chk_idle("ovr_end");

    // 5. Back-to-back: new rise on the word-7 handshake edge
    launch(pa);
    for (int i = 0; i < 7; i++) step();
    chk("b2b_w7", 64'(stream.dout_last), 64'd1);
    yout = pb;
    done = 1'b1;
    step();
    done = 1'b0;
    chk("b2b_dout",  64'(stream.dout),       64'h0000_00A0);
    chk("b2b_valid", 64'(stream.dout_valid), 64'd1);
    chk("b2b_ovr",   64'(overrun),           64'd0);
    chk("b2b_last",  64'(stream.dout_last),  64'd0);
    drain("b2b", pb, 0);
    chk_idle("b2b_end");

    // 6. Asynchronous reset after word 2, then a fresh product
    launch(pa);
    for (int i = 0; i < 3; i++) step();
    chk("mrst_pre", 64'(stream.dout), 64'(word_of(pa, 3)));
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("mrst_async");
    chk("mrst_ovr", 64'(overrun), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_idle("mrst_released");
    launch(pb);
    drain("mrst_fresh", pb, 0);
    chk_idle("mrst_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_result_serializer.md
Name: mul_result_serializer

Overview:
- Sits directly downstream of the 128x128 sequential multiplier.
- Captures the 256-bit product when the multiplier's done rises.
- Streams the product out as OUT_W-bit words over a valid/ready interface, least-significant word first.
- Decouples the wide product from the narrow result bus and flags products lost because the serializer was still busy.

Parameters:
- PROD_W, 256: product width; must be an integer multiple of OUT_W.
- OUT_W, 32: output word width.
- NWORDS, PROD_W/OUT_W (8): words per product; derived, not overridden.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- done, input, 1: multiplier completion; may be a pulse or a level, only its rising edge is used.
- yout, input, PROD_W: multiplier product; valid in the cycle done rises.
- dout, output, OUT_W: current output word.
- dout_valid, output, 1: dout holds a valid word.
- dout_ready, input, 1: consumer accepts the word.
- dout_last, output, 1: the current word is word NWORDS-1.
- busy, output, 1: a product is captured and not fully sent.
- overrun, output, 1: one-cycle pulse; a product was dropped.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Outputs: dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0.
  - Internal: state=IDLE, shift register=0, word index=0, done_d=0.
- Edge detect:
  - done_d is a register holding done from the previous cycle; rise = done & ~done_d.
  - If done is high on the first edge after reset release, that counts as a rise.
- IDLE:
  - On an edge with rise=1: capture yout, set index=0, go to SEND.
  - dout_valid, busy and dout = yout[OUT_W-1:0] become visible in the next cycle (1-cycle latency from the done edge).
- SEND:
  - dout = word[index], with word i = captured[i*OUT_W +: OUT_W].
  - dout_last = (index==NWORDS-1).
  - A handshake is an edge with dout_valid & dout_ready; on each one, index increments.
  - With dout_ready low, dout, dout_last and dout_valid hold unchanged. dout_valid never drops mid-product.
  - After the handshake on the last word:
    - If rise=1 on that same edge: capture the new yout, index=0, stay in SEND. No bubble, no overrun.
    - Otherwise: go to IDLE with dout_valid=0, busy=0, dout=0.
- Rise in SEND, not on the last-word handshake edge:
  - The new product is discarded and overrun pulses high for exactly one cycle.
  - The in-flight product is unaffected.
- Index counter: $clog2(NWORDS) bits, never wraps; it is reset to 0 at capture.
- Reset mid-stream aborts immediately. Outputs return to reset values with no partial last word.
- Throughput: with dout_ready held high, one product takes NWORDS cycles.

Decomposition:
- Shared package mul_pkg holds:
  - constants PROD_W=256, OUT_W=32, NWORDS=8;
  - the state enum {IDLE, SEND};
  - a typedef for the PROD_W-wide product vector.
- The multiplier and its benches import the same package.
- One natural sub-module: rise_detect (done_d register plus rise output, async active-low reset), reusable for the multiplier's start input.
- Everything else stays inline.

Test Plan:
1. Basic stream:
   - Stimulus: reset 1us, yout words i=0..7 = 32'h11111111*(i+1), single-cycle done pulse, dout_ready=1.
   - Required: dout_valid one cycle after the done edge; dout = 11111111, 22222222 … 88888888 on consecutive cycles; dout_last only with 88888888; then IDLE with busy=0.
2. Backpressure:
   - Stimulus: same product, dout_ready toggling 1,0,0,1 repeating.
   - Required: dout holds while ready is low; all 8 words appear in order with no duplicates or losses.
3. Level done:
   - Stimulus: done held high for 1000 cycles.
   - Required: exactly one product is sent; overrun=0.
4. Overrun:
   - Stimulus: second done rise, yout=all-F, while word 3 of the first product is pending.
   - Required: overrun high for 1 cycle; the first product completes intact; no F words emitted.
5. Back-to-back:
   - Stimulus: second rise (words 0xA0..0xA7) on the same edge as the word-7 handshake.
   - Required: next cycle dout=0xA0 with dout_valid held high continuously; overrun=0.
6. Reset mid-stream:
   - Stimulus: rst_n low after word 2.
   - Required: all outputs 0 asynchronously; after release, a fresh product streams from word 0.
